// File: rtl/rv32imf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32imf_pkg
// Brief   : Shared types and constants for the rv32imf instruction fetch path.
// Revision: 1.0
// ============================================================================
package rv32imf_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE        = 2'd0,
    FETCH_BUSY        = 2'd1,
    FETCH_BRANCH_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/rv32imf_fetch_requester_if.sv
`default_nettype none
// ============================================================================
// Module  : rv32imf_fetch_requester_if
// Brief   : Instruction bus (req/gnt/rvalid) plus prefetch FIFO write port.
// Revision: 1.0
// ============================================================================
interface rv32imf_fetch_requester_if #(
  parameter int CNT_W = 1
);
  logic             instr_req_o;
  logic [31:0]      instr_addr_o;
  logic             instr_gnt_i;
  logic             instr_rvalid_i;
  logic [31:0]      instr_rdata_i;
  logic             fifo_push_o;
  logic [31:0]      fifo_data_o;
  logic             fifo_flush_o;
  logic [CNT_W:0]   fifo_cnt_i;

  modport master (
    output instr_req_o, instr_addr_o, fifo_push_o, fifo_data_o, fifo_flush_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, fifo_cnt_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, fifo_push_o, fifo_data_o, fifo_flush_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, fifo_cnt_i
  );
endinterface
`default_nettype wire

// File: rtl/rv32imf_fetch_requester.sv
`default_nettype none
// ============================================================================
// Module  : rv32imf_fetch_requester
// Brief   : Credit-limited instruction fetch initiator; write end of the
//           prefetch FIFO, drops stale responses after a redirect.
// Revision: 1.0
// ============================================================================
module rv32imf_fetch_requester
  import rv32imf_pkg::*;
#(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        busy_o,
  rv32imf_fetch_requester_if.master bus
);

  localparam int          c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] c_DEPTH = 32'(DEPTH);
  localparam logic [31:0] c_MAX   = 32'(MAX_OUTSTANDING);

  fetch_state_e       r_state, w_state_d;
  logic [31:0]        r_fetch_addr, w_addr_d;
  logic [31:0]        r_target, w_target_d;
  logic [c_OUT_W-1:0] r_outstanding, w_out_d;
  logic [c_OUT_W-1:0] r_discard, w_disc_d;
  logic               r_pend, w_pend_d;

  logic [31:0] w_out_ext;
  logic [31:0] w_cnt_ext;
  logic        w_credit;
  logic        w_req;
  logic        w_gnt;
  logic        w_hold;
  logic        w_rvalid;
  logic        w_drop;

  // Registered occupancy only: a response pushed now is still in r_outstanding.
  assign w_out_ext = {{(32-c_OUT_W){1'b0}}, r_outstanding};
  assign w_cnt_ext = {{(31-CNT_W){1'b0}}, bus.fifo_cnt_i};
  assign w_credit  = ((w_out_ext + w_cnt_ext) < c_DEPTH) && (w_out_ext < c_MAX);

  assign w_req    = r_pend | ((r_state == FETCH_BUSY) & req_i & w_credit);
  assign w_gnt    = w_req & bus.instr_gnt_i;
  assign w_hold   = w_req & ~bus.instr_gnt_i;
  assign w_rvalid = bus.instr_rvalid_i;
  assign w_drop   = w_rvalid & (r_discard != '0);

  assign bus.instr_req_o  = w_req;
  assign bus.instr_addr_o = r_fetch_addr;
  assign bus.fifo_push_o  = w_rvalid & ~branch_i & (r_discard == '0);
  assign bus.fifo_data_o  = bus.instr_rdata_i;
  assign bus.fifo_flush_o = branch_i;
  assign busy_o           = w_req | (r_outstanding != '0);

  always_comb begin
    w_state_d  = r_state;
    w_addr_d   = r_fetch_addr;
    w_target_d = r_target;
    w_pend_d   = w_hold;
    w_out_d    = r_outstanding + c_OUT_W'(w_gnt) - c_OUT_W'(w_rvalid);
    w_disc_d   = r_discard - c_OUT_W'(w_drop)
               + c_OUT_W'((r_state == FETCH_BRANCH_WAIT) && w_gnt);

    if (branch_i) begin
      // Everything in flight, including a grant this cycle, is now stale.
      w_disc_d = w_out_d;
      if (w_hold) begin
        w_target_d = branch_addr_i & INSTR_ALIGN_MASK;
        w_state_d  = FETCH_BRANCH_WAIT;
      end else begin
        w_addr_d  = branch_addr_i & INSTR_ALIGN_MASK;
        w_state_d = req_i ? FETCH_BUSY : FETCH_IDLE;
      end
    end else begin
      unique case (r_state)
        FETCH_IDLE: begin
          if (req_i) w_state_d = FETCH_BUSY;
        end
        FETCH_BUSY: begin
          if (w_gnt) w_addr_d = r_fetch_addr + 32'd4;
          if (!req_i && !w_hold) w_state_d = FETCH_IDLE;
        end
        FETCH_BRANCH_WAIT: begin
          if (w_gnt) begin
            w_addr_d  = r_target;
            w_state_d = req_i ? FETCH_BUSY : FETCH_IDLE;
          end
        end
        default: w_state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= FETCH_IDLE;
      r_fetch_addr  <= '0;
      r_target      <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_pend        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_fetch_addr  <= w_addr_d;
      r_target      <= w_target_d;
      r_outstanding <= w_out_d;
      r_discard     <= w_disc_d;
      r_pend        <= w_pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32imf_fetch_requester.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32imf_fetch_requester
// Brief   : Directed bench with a transaction-level model of the fetcher.
// Revision: 1.0
// ============================================================================
module tb_rv32imf_fetch_requester;

  localparam int DEPTH = 2;
  localparam int MAXO  = 2;
  localparam int CNT_W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr;
  logic        busy;
  bit          gnt_en;
  bit          rsp_en;
  logic [CNT_W:0] cnt_knob;

  int n_checks = 0;
  int n_errors = 0;

  rv32imf_fetch_requester_if #(.CNT_W(CNT_W)) bus ();

  rv32imf_fetch_requester #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr), .busy_o(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.instr_gnt_i = gnt_en;
  assign bus.fifo_cnt_i  = cnt_knob;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // In-order memory: returns word_of(addr) for each granted address.
  logic [31:0] bq[$];
  always @(negedge clk) begin
    if (rst) bq.delete();
    else begin
      if (bus.instr_rvalid_i && bq.size() > 0) void'(bq.pop_front());
      if (bus.instr_req_o && bus.instr_gnt_i) bq.push_back(bus.instr_addr_o);
    end
  end
  always begin
    @(posedge clk);
    #2;
    bus.instr_rvalid_i = !rst && rsp_en && (bq.size() > 0);
    bus.instr_rdata_i  = (bq.size() > 0) ? word_of(bq[0]) : 32'h0;
  end

  // Transaction model: every in-flight fetch with its stale flag.
  typedef struct { logic [31:0] addr; bit stale; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_next, m_target, p_addr;
  bit          m_wait, p_req_i, p_req_o, p_gnt;
  bit          held, room, exp_req, exp_push, gnt_now;
  logic [31:0] g_log[$];
  logic [31:0] p_log[$];

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_next = '0; m_target = '0; m_wait = 0;
      p_req_i = 0; p_req_o = 0; p_gnt = 0; p_addr = '0;
    end else begin
      held    = p_req_o && !p_gnt;
      room    = (mq.size() + int'(bus.fifo_cnt_i) < DEPTH) && (mq.size() < MAXO);
      exp_req = held || (p_req_i && req_i && !m_wait && room);
      chk("instr_req", 32'(bus.instr_req_o), 32'(exp_req));
      if (bus.instr_req_o)
        chk("instr_addr", bus.instr_addr_o, held ? p_addr : m_next);
      chk("fifo_flush", 32'(bus.fifo_flush_o), 32'(branch_i));
      exp_push = bus.instr_rvalid_i && !branch_i && mq.size() > 0 && !mq[0].stale;
      chk("fifo_push", 32'(bus.fifo_push_o), 32'(exp_push));
      if (exp_push) chk("fifo_data", bus.fifo_data_o, word_of(mq[0].addr));
      chk("busy", 32'(busy), 32'(bus.instr_req_o || mq.size() != 0));

      if (bus.fifo_push_o) p_log.push_back(bus.fifo_data_o);
      if (bus.instr_rvalid_i && mq.size() > 0) void'(mq.pop_front());
      if (branch_i) foreach (mq[i]) mq[i].stale = 1;
      gnt_now = bus.instr_req_o && bus.instr_gnt_i;
      if (gnt_now) begin
        mq.push_back('{addr: bus.instr_addr_o, stale: (m_wait || branch_i)});
        g_log.push_back(bus.instr_addr_o);
      end
      if (branch_i) begin
        if (bus.instr_req_o && !bus.instr_gnt_i) begin
          m_wait = 1; m_target = branch_addr & 32'hFFFF_FFFC;
        end else begin
          m_wait = 0; m_next = branch_addr & 32'hFFFF_FFFC;
        end
      end else if (gnt_now) begin
        m_next = m_wait ? m_target : bus.instr_addr_o + 32'd4;
        m_wait = 0;
      end
      p_req_i = req_i; p_req_o = bus.instr_req_o;
      p_gnt = bus.instr_gnt_i; p_addr = bus.instr_addr_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    g_log.delete();
    p_log.delete();
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst = 1; req_i = 0; branch_i = 0; branch_addr = '0;
    gnt_en = 0; rsp_en = 0; cnt_knob = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(bus.instr_req_o),  32'd0);
    chk("rst_addr",  bus.instr_addr_o,      32'd0);
    chk("rst_push",  32'(bus.fifo_push_o),  32'd0);
    chk("rst_flush", 32'(bus.fifo_flush_o), 32'd0);
    chk("rst_busy",  32'(busy),             32'd0);
    step();
    rst = 0;

    // Boot branch to 0x83 -> fetches 0x80, 0x84, then stall at two in flight.
    clear_logs();
    gnt_en = 1; rsp_en = 0; req_i = 1; branch_i = 1; branch_addr = 32'h0000_0083;
    step();
    branch_i = 0;
    wait_n(5);
    chk("t1_grants", 32'(g_log.size()), 32'd2);
    chk("t1_addr0",  qget(g_log, 0), 32'h0000_0080);
    chk("t1_addr1",  qget(g_log, 1), 32'h0000_0084);
    #3;
    chk("t1_stall_req", 32'(bus.instr_req_o), 32'd0);
    step();
    req_i = 0; rsp_en = 1;
    wait_n(5);
    chk("t1_pushes", 32'(p_log.size()), 32'd2);
    chk("t1_pushA",  qget(p_log, 0), 32'hC0DE_0080);
    chk("t1_pushB",  qget(p_log, 1), 32'hC0DE_0084);

    // FIFO full blocks requests; one slot admits exactly one.
    clear_logs();
    cnt_knob = 2; req_i = 1; rsp_en = 0;
    wait_n(5);
    chk("t2_blocked", 32'(g_log.size()), 32'd0);
    step();
    cnt_knob = 1;
    wait_n(5);
    chk("t2_one_req", 32'(g_log.size()), 32'd1);
    chk("t2_addr",    qget(g_log, 0), 32'h0000_0088);
    step();
    req_i = 0; cnt_knob = 0; rsp_en = 1;
    wait_n(5);
    chk("t2_push", qget(p_log, 0), 32'hC0DE_0088);

    // Grant withheld five cycles, req_i dropped meanwhile.
    clear_logs();
    gnt_en = 0; rsp_en = 1; req_i = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t3_req_hold",  32'(bus.instr_req_o), 32'd1);
      chk("t3_addr_hold", bus.instr_addr_o, 32'h0000_008C);
      step();
      if (i == 1) req_i = 0;
    end
    gnt_en = 1;
    step();
    gnt_en = 0;
    wait_n(4);
    chk("t3_grants", 32'(g_log.size()), 32'd1);
    chk("t3_push",   qget(p_log, 0), 32'hC0DE_008C);
    #3;
    chk("t3_idle_busy", 32'(busy), 32'd0);
    step();

    // Branch to 0x300 while 0x90 is pending ungranted.
    clear_logs();
    gnt_en = 0; rsp_en = 1; req_i = 1;
    step();
    branch_i = 1; branch_addr = 32'h0000_0301;
    #3;
    chk("t5_flush",    32'(bus.fifo_flush_o), 32'd1);
    chk("t5_old_addr", bus.instr_addr_o, 32'h0000_0090);
    step();
    branch_i = 0;
    #3;
    chk("t5_held_addr", bus.instr_addr_o, 32'h0000_0090);
    step();
    gnt_en = 1;
    wait_n(4);
    req_i = 0;
    wait_n(6);
    chk("t5_grant0", qget(g_log, 0), 32'h0000_0090);
    chk("t5_grant1", qget(g_log, 1), 32'h0000_0300);
    chk("t5_push0",  qget(p_log, 0), 32'hC0DE_0300);

    // Two in flight, branch to 0x200: both responses dropped.
    clear_logs();
    gnt_en = 1; rsp_en = 0; req_i = 1; branch_i = 1; branch_addr = 32'h0000_0100;
    step();
    branch_i = 0;
    wait_n(4);
    chk("t4_inflight", 32'(g_log.size()), 32'd2);
    branch_i = 1; branch_addr = 32'h0000_0200;
    #3;
    chk("t4_flush", 32'(bus.fifo_flush_o), 32'd1);
    step();
    branch_i = 0; rsp_en = 1;
    wait_n(6);
    req_i = 0;
    wait_n(6);
    chk("t4_grant2", qget(g_log, 2), 32'h0000_0200);
    chk("t4_push0",  qget(p_log, 0), 32'hC0DE_0200);

    // Address wrap, then asynchronous reset with fetches in flight.
    clear_logs();
    gnt_en = 1; rsp_en = 0; req_i = 1; branch_i = 1; branch_addr = 32'hFFFF_FFFE;
    step();
    branch_i = 0;
    wait_n(4);
    chk("t6_top",  qget(g_log, 0), 32'hFFFF_FFFC);
    chk("t6_wrap", qget(g_log, 1), 32'h0000_0000);
    #2;
    rst = 1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_req",  32'(bus.instr_req_o), 32'd0);
    req_i = 0;
    wait_n(2);
    rst = 0;
    wait_n(3);
    #3;
    chk("t6_after_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
